// File: rtl/stream_demux.sv
// One-deep registered demux: each beat goes to lane in_sel one cycle after accept; a lane only backpressures beats aimed at it.
// Optional STREAM_DEMUX_ERR_EN adds a sticky err_sel flag and a saturating err_cnt for out-of-range selects.
module stream_demux #(
  parameter int DATA_WIDTH = 1,
  parameter int OUTPUTS_NUM = 3,
  localparam int SELECT_WIDTH = $clog2(OUTPUTS_NUM)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [SELECT_WIDTH-1:0] in_sel,
  output logic                    in_ready,
  output logic [OUTPUTS_NUM-1:0]  out_valid,
  output logic [DATA_WIDTH-1:0]   outputs_arr [0:OUTPUTS_NUM-1],
  input  logic [OUTPUTS_NUM-1:0]  out_ready
`ifdef STREAM_DEMUX_ERR_EN
  ,
  output logic                    err_sel,
  output logic [7:0]              err_cnt
`endif
);

  logic [OUTPUTS_NUM-1:0] sel_hit;
  logic [OUTPUTS_NUM-1:0] load;
  logic                   in_range;
  logic                   lane_free;

  // Out-of-range selects are always accepted so they can be dropped without stalling the stream.
  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < OUTPUTS_NUM; k++) begin
      sel_hit[k] = (in_sel == SELECT_WIDTH'(k));
    end
    in_range  = |sel_hit;
    lane_free = |(sel_hit & (~out_valid | out_ready));
    in_ready  = in_range ? lane_free : 1'b1;
    load      = (in_valid && in_ready) ? sel_hit : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < OUTPUTS_NUM; k++) begin
        out_valid[k]   <= 1'b0;
        outputs_arr[k] <= '0;
      end
    end else begin
      for (int k = 0; k < OUTPUTS_NUM; k++) begin
        if (load[k]) begin
          out_valid[k]   <= 1'b1;
          outputs_arr[k] <= in_data;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

`ifdef STREAM_DEMUX_ERR_EN
  logic bad_beat;
  assign bad_beat = in_valid && !in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sel <= 1'b0;
      err_cnt <= 8'd0;
    end else if (bad_beat) begin
      err_sel <= 1'b1;
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux (3 lanes, 8-bit data); directed vectors, per-lane expected queues.
module tb_stream_demux;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic       in_ready;
  logic [2:0] out_valid;
  logic [7:0] outputs_arr [0:2];
  logic [2:0] out_ready;
`ifdef STREAM_DEMUX_ERR_EN
  logic       err_sel;
  logic [7:0] err_cnt;
`endif

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [7:0] exp_q [3][$];
  logic [2:0] stall_prev = '0;
  logic [7:0] held [3];

  always #5 clk = ~clk;

  stream_demux #(.DATA_WIDTH(8), .OUTPUTS_NUM(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_sel(in_sel),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .outputs_arr(outputs_arr),
    .out_ready(out_ready)
`ifdef STREAM_DEMUX_ERR_EN
    ,
    .err_sel(err_sel),
    .err_cnt(err_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
  endtask

  // Monitor: pops on every handshake and checks stalled lanes stay frozen.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (stall_prev[k]) begin
          chk($sformatf("stall_valid%0d", k), {31'd0, out_valid[k]}, 32'd1);
          chk($sformatf("stall_data%0d", k), {24'd0, outputs_arr[k]}, {24'd0, held[k]});
        end
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            chk_cnt++;
            $display("FAIL lane%0d unexpected beat: got %0h required none at %0t", k, outputs_arr[k], $time);
          end else begin
            chk($sformatf("lane%0d_data", k), {24'd0, outputs_arr[k]}, {24'd0, exp_q[k].pop_front()});
          end
        end
        stall_prev[k] = out_valid[k] && !out_ready[k];
        held[k] = outputs_arr[k];
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat for one cycle; exp_rdy is the hand-computed in_ready.
  task automatic send(input int sel, input logic [7:0] d, input logic exp_rdy);
    in_valid = 1'b1;
    in_sel   = 2'(sel);
    in_data  = d;
    @(negedge clk);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    if (exp_rdy && sel < 3) exp_q[sel].push_back(d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (exp_rdy && sel < 3) chk("latency_valid", {31'd0, out_valid[sel]}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'd0; out_ready = 3'b111;
    #2;
    chk("reset_valid", {29'd0, out_valid}, 32'd0);
    for (int k = 0; k < 3; k++) chk("reset_data", {24'd0, outputs_arr[k]}, 32'd0);
`ifdef STREAM_DEMUX_ERR_EN
    chk("reset_err_sel", {31'd0, err_sel}, 32'd0);
    chk("reset_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Back-to-back beats to all lanes, all ready.
    send(0, 8'h11, 1'b1);
    send(1, 8'h22, 1'b1);
    send(2, 8'h33, 1'b1);
    idle(2);

    // Idle input with garbage sel/data must not touch any lane.
    in_sel = 2'd1; in_data = 8'hEE;
    idle(3);
    chk("idle_no_valid", {29'd0, out_valid}, 32'd0);

    // Lane 1 stalled; lane 0 must still flow.
    out_ready = 3'b101;
    send(1, 8'hA1, 1'b1);
    send(1, 8'hA2, 1'b0);
    chk("stall_hold_a1", {24'd0, outputs_arr[1]}, 32'hA1);
    send(0, 8'hB0, 1'b1);
    chk("lane1_still_valid", {31'd0, out_valid[1]}, 32'd1);
    chk("lane1_still_a1", {24'd0, outputs_arr[1]}, 32'hA1);
    idle(2);
    out_ready = 3'b111;
    idle(2);

    // Simultaneous drain and load of lane 2.
    send(2, 8'h44, 1'b1);
    send(2, 8'h5C, 1'b1);
    chk("replace_data", {24'd0, outputs_arr[2]}, 32'h5C);
    idle(2);

    // Asynchronous reset mid-stream with lanes 0 and 2 full.
    out_ready = 3'b000;
    send(0, 8'h61, 1'b1);
    send(2, 8'h62, 1'b1);
    chk("pre_reset_valid", {29'd0, out_valid}, 32'h5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", {29'd0, out_valid}, 32'd0);
    for (int k = 0; k < 3; k++) chk("async_reset_data", {24'd0, outputs_arr[k]}, 32'd0);
    for (int k = 0; k < 3; k++) exp_q[k].delete();
    idle(2);
    out_ready = 3'b111;
    rst_n = 1'b1;
    send(0, 8'h77, 1'b1);
    idle(2);

    // Out-of-range selects: accepted and dropped.
    for (int i = 0; i < 260; i++) begin
      send(3, 8'(i), 1'b1);
`ifdef STREAM_DEMUX_ERR_EN
      if (i == 0) chk("err_cnt_first", {24'd0, err_cnt}, 32'd1);
`endif
    end
    chk("bad_sel_no_valid", {29'd0, out_valid}, 32'd0);
`ifdef STREAM_DEMUX_ERR_EN
    chk("err_sel_sticky", {31'd0, err_sel}, 32'd1);
    chk("err_cnt_saturate", {24'd0, err_cnt}, 32'd255);
`endif

    idle(3);
    for (int k = 0; k < 3; k++) chk("drain_empty", exp_q[k].size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
